// File: rtl/regfile_dump.sv
// regfile_dump
//   Debug read-out engine for the register file. On start it walks one
//   regfile read port over x0..x(NREGS-1) and streams each index/value pair
//   to the debug host link over a valid/ready interface. Read-only: the
//   engine never writes the register file.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   start_i       begin a dump (only looked at while idle)
//   abort_i       cancel a dump in progress (FETCH/SEND only)
//   rd_sel_o      register select to the regfile read port (always == idx)
//   rd_data_i     combinational read data returned by the regfile
//   dump_valid_o  dump_idx_o/dump_data_o/dump_last_o hold a word
//   dump_ready_i  sink accepts the word when high together with valid
//   dump_idx_o    register index of the word on offer
//   dump_data_o   register value of the word on offer
//   dump_last_o   word on offer is index NREGS-1
//   busy_o        engine is anywhere but idle
//   done_o        one-cycle pulse after the last word was accepted
module regfile_dump #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32,
  parameter int SEL_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  output logic [SEL_W-1:0] rd_sel_o,
  input  logic [XLEN-1:0]  rd_data_i,
  output logic             dump_valid_o,
  input  logic             dump_ready_i,
  output logic [SEL_W-1:0] dump_idx_o,
  output logic [XLEN-1:0]  dump_data_o,
  output logic             dump_last_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } dumpStateT;

  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(NREGS - 1);

  dumpStateT        state;
  dumpStateT        nextState;
  logic [SEL_W-1:0] idx;
  logic             handshake;

  // The read select comes straight off the idx register, so the regfile
  // address only ever changes on a clock edge and never shows a stray index.
  assign rd_sel_o  = idx;
  assign handshake = dump_valid_o & dump_ready_i;

  // State register. Reset drops the engine back to idle, which also clears
  // valid/busy/done because those are decoded from the state alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and status decode. Abort only matters while a word is being
  // fetched or offered; in idle a start always wins and DONE always pulses.
  // A word handshaked in the same cycle as an abort has already left, so the
  // abort simply ends the sweep without a done pulse.
  always_comb begin
    nextState    = state;
    dump_valid_o = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          nextState = FETCH;
        end
      end
      FETCH: begin
        nextState = abort_i ? IDLE : SEND;
      end
      SEND: begin
        dump_valid_o = 1'b1;
        if (abort_i) begin
          nextState = IDLE;
        end else if (handshake) begin
          nextState = dump_last_o ? DONE : FETCH;
        end
      end
      DONE: begin
        done_o    = 1'b1;
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Index counter and output word capture. The word is sampled exactly once
  // per index in FETCH and then held untouched through SEND, so regfile
  // writes that land while the sink stalls cannot alter a word on offer.
  // The index is parked at zero whenever a sweep ends, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      dump_idx_o  <= '0;
      dump_data_o <= '0;
      dump_last_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            idx <= '0;
          end
        end
        FETCH: begin
          if (abort_i) begin
            idx <= '0;
          end else begin
            dump_data_o <= rd_data_i;
            dump_idx_o  <= idx;
            dump_last_o <= (idx == LastIdx);
          end
        end
        SEND: begin
          if (abort_i) begin
            idx <= '0;
          end else if (handshake) begin
            idx <= dump_last_o ? '0 : idx + SEL_W'(1);
          end
        end
        DONE: begin
          idx <= '0;
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

endmodule
